// File: rtl/firebird7_in_gate1_tessent_mux_ctrl_pkg.sv
// Shared types and constants for the gate1 IJTAG data mux controller.
// Sequencer states, counter width and default sizing.
package firebird7_in_gate1_tessent_mux_ctrl_pkg;

    localparam int DEF_WIDTH  = 19;
    localparam int DEF_SETTLE = 2;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        SELECT = 2'd2,
        DRAIN  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_shift.sv
// IJTAG test data register: capture/shift/update chain plus shadow.
// MSB of the chain is the enable request, the rest is override data.
module firebird7_in_gate1_tessent_tdr_shift
    import firebird7_in_gate1_tessent_mux_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    input  logic [WIDTH-1:0] capture_data,
    output logic             ijtag_so,
    output logic             shadow_en,
    output logic [WIDTH-1:0] shadow_data,
    output logic             shadow_upd
);

    logic [WIDTH:0] shift_reg;

    // Scan chain: capture beats shift; update does not touch the chain.
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            shift_reg <= '0;
        end else if (ijtag_sel) begin
            if (ijtag_ce) begin
                shift_reg <= {shadow_en, capture_data};
            end else if (ijtag_se) begin
                shift_reg <= {ijtag_si, shift_reg[WIDTH:1]};
            end
        end
    end

    // Shadow load on update only when no capture/shift is requested.
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            shadow_en   <= 1'b0;
            shadow_data <= '0;
            shadow_upd  <= 1'b0;
        end else begin
            shadow_upd <= 1'b0;
            if (ijtag_sel && !ijtag_ce && !ijtag_se && ijtag_ue) begin
                shadow_en   <= shift_reg[WIDTH];
                shadow_data <= shift_reg[WIDTH-1:0];
                shadow_upd  <= 1'b1;
            end
        end
    end

    assign ijtag_so = shift_reg[0];

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG override controller for the gate1 functional/IJTAG data mux.
// Break-before-make: data settles before select rises, select drains.
module firebird7_in_gate1_tessent_data_mux_ctrl
    import firebird7_in_gate1_tessent_mux_ctrl_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic [WIDTH-1:0] mux_data_out,
    output logic             mux_select,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic             shadow_en;
    logic [WIDTH-1:0] shadow_data;
    logic             shadow_upd;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;

    firebird7_in_gate1_tessent_tdr_shift #(
        .WIDTH(WIDTH)
    ) u_tdr (
        .ijtag_tck    (ijtag_tck),
        .ijtag_reset  (ijtag_reset),
        .ijtag_sel    (ijtag_sel),
        .ijtag_ce     (ijtag_ce),
        .ijtag_se     (ijtag_se),
        .ijtag_ue     (ijtag_ue),
        .ijtag_si     (ijtag_si),
        .capture_data (functional_data_in),
        .ijtag_so     (ijtag_so),
        .shadow_en    (shadow_en),
        .shadow_data  (shadow_data),
        .shadow_upd   (shadow_upd)
    );

    // Sequencer state, counter and registered mux-facing outputs.
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            state_q <= IDLE;
            count_q <= '0;
            data_q  <= '0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: settle in ARM, drain after select drops.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (shadow_en) state_d = ARM;
            end
            ARM: begin
                if (!shadow_en) begin
                    state_d = IDLE;
                end else if (!shadow_upd && count_q == LAST) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (!shadow_en) state_d = DRAIN;
            end
            DRAIN: begin
                if (count_q == LAST) state_d = IDLE;
            end
        endcase
    end

    // Data/counter updates; select and busy decoded from next state.
    always_comb begin
        count_d = count_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                data_d  = shadow_data;
                count_d = '0;
            end
            ARM: begin
                if (shadow_upd && shadow_en) begin
                    data_d  = shadow_data;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            SELECT: begin
                if (shadow_en) data_d = shadow_data;
                count_d = '0;
            end
            DRAIN: begin
                count_d = count_q + CNT_W'(1);
            end
        endcase
        sel_d  = (state_d == SELECT);
        busy_d = (state_d == ARM) || (state_d == DRAIN);
    end

    assign mux_data_out = data_q;
    assign mux_select   = sel_q;
    assign busy         = busy_q;

endmodule
